// File: rtl/alu_arbiter_if.sv
// Bundles the two request channels, the ALU drive/return signals, the tagged
// response channel and the status outputs of alu_arbiter. The slave modport is
// the arbiter's view. The master modport is the surrounding system's view:
// the requesters, the ALU and the response consumer.
interface alu_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 4,
   parameter int CNT_W = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [SEL_W-1:0] req0_sel;
   logic             req0_cin;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [SEL_W-1:0] req1_sel;
   logic             req1_cin;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [SEL_W-1:0] alu_sel;
   logic             alu_cin;
   logic [WIDTH-1:0] alu_y;
   logic             alu_cout;
   logic             alu_neg;
   logic             alu_zero;
   logic             alu_ovf;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_y;
   logic [3:0]       rsp_flags;
   logic             rsp_err;

   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;
   logic             busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sel, req0_cin,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_sel, req1_cin,
      output req1_ready,
      output alu_a, alu_b, alu_sel, alu_cin,
      input  alu_y, alu_cout, alu_neg, alu_zero, alu_ovf,
      output rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err,
      input  rsp_ready,
      output cnt0, cnt1, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_sel, req0_cin,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_sel, req1_cin,
      input  req1_ready,
      input  alu_a, alu_b, alu_sel, alu_cin,
      output alu_y, alu_cout, alu_neg, alu_zero, alu_ovf,
      input  rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err,
      output rsp_ready,
      input  cnt0, cnt1, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. Arbitration is
// round-robin. Each operation is accepted in IDLE and presented to the ALU for
// one ISSUE cycle. Its result is then held on a tagged response channel
// (RESP) until the consumer takes it. Illegal select codes skip the ALU and
// answer with an error response.
module alu_arbiter #(
   parameter int WIDTH   = 32,
   parameter int SEL_W   = 4,
   parameter int MAX_SEL = 5,
   parameter int CNT_W   = 16
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);
   localparam logic [SEL_W-1:0] MAX_SEL_C = SEL_W'(MAX_SEL);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t state_reg, state_next;

   logic             last_grant_reg;
   logic             id_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [SEL_W-1:0] sel_reg;
   logic             cin_reg;
   logic [WIDTH-1:0] y_reg;
   logic [3:0]       flags_reg;
   logic             err_reg;
   logic [CNT_W-1:0] cnt0_reg;
   logic [CNT_W-1:0] cnt1_reg;

   logic             grant_id;
   logic             any_valid;
   logic             accept;
   logic             sel_legal;
   logic [WIDTH-1:0] cap_a;
   logic [WIDTH-1:0] cap_b;
   logic [SEL_W-1:0] cap_sel;
   logic             cap_cin;

   // Round-robin grant: a lone requester wins; on a tie the port that did not win last time wins.
   always_comb begin
      grant_id  = 1'b0;
      any_valid = bus.req0_valid | bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         grant_id = ~last_grant_reg;
      end else if (bus.req1_valid) begin
         grant_id = 1'b1;
      end
   end

   assign accept         = (state_reg == IDLE) && any_valid;
   assign bus.req0_ready = accept && !grant_id;
   assign bus.req1_ready = accept && grant_id;

   // Select the granted requester's operation and check its select code.
   always_comb begin
      cap_a   = bus.req0_a;
      cap_b   = bus.req0_b;
      cap_sel = bus.req0_sel;
      cap_cin = bus.req0_cin;
      if (grant_id) begin
         cap_a   = bus.req1_a;
         cap_b   = bus.req1_b;
         cap_sel = bus.req1_sel;
         cap_cin = bus.req1_cin;
      end
      sel_legal = (cap_sel <= MAX_SEL_C);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state: an illegal op goes straight to RESP because it never uses the ALU.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = sel_legal ? ISSUE : RESP;
            end
         end
         ISSUE: begin
            state_next = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Capture operands on accept, latch the ALU result in ISSUE, count delivered responses in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_reg <= 1'b1;
         id_reg         <= 1'b0;
         a_reg          <= '0;
         b_reg          <= '0;
         sel_reg        <= '0;
         cin_reg        <= 1'b0;
         y_reg          <= '0;
         flags_reg      <= '0;
         err_reg        <= 1'b0;
         cnt0_reg       <= '0;
         cnt1_reg       <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  id_reg         <= grant_id;
                  last_grant_reg <= grant_id;
                  if (sel_legal) begin
                     // Operand registers move only for ops that reach the ALU.
                     a_reg   <= cap_a;
                     b_reg   <= cap_b;
                     sel_reg <= cap_sel;
                     cin_reg <= cap_cin;
                  end else begin
                     y_reg     <= '0;
                     flags_reg <= '0;
                     err_reg   <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               y_reg     <= bus.alu_y;
               flags_reg <= {bus.alu_cout, bus.alu_neg, bus.alu_zero, bus.alu_ovf};
               err_reg   <= 1'b0;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  if (!id_reg) begin
                     if (cnt0_reg != '1) cnt0_reg <= cnt0_reg + 1'b1;
                  end else begin
                     if (cnt1_reg != '1) cnt1_reg <= cnt1_reg + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // The ALU sees the captured registers continuously, so its inputs stay quiet between ops.
   assign bus.alu_a     = a_reg;
   assign bus.alu_b     = b_reg;
   assign bus.alu_sel   = sel_reg;
   assign bus.alu_cin   = cin_reg;

   assign bus.rsp_valid = (state_reg == RESP);
   assign bus.rsp_id    = id_reg;
   assign bus.rsp_y     = y_reg;
   assign bus.rsp_flags = flags_reg;
   assign bus.rsp_err   = err_reg;
   assign bus.cnt0      = cnt0_reg;
   assign bus.cnt1      = cnt1_reg;
   assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. It provides a behavioural ALU, per-port request
// queues and a scoreboard of expected responses in grant order. The counters
// are built 2 bits wide so that saturation is reachable.
module tb_alu_arbiter;
   localparam int W  = 32;
   localparam int SW = 4;
   localparam int CW = 2;

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [SW-1:0] sel;
      logic          cin;
   } op_t;

   typedef struct {
      logic          id;
      logic [W-1:0]  y;
      logic [3:0]    f;
      logic          err;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(W), .SEL_W(SW), .CNT_W(CW)) bus ();

   alu_arbiter #(.WIDTH(W), .SEL_W(SW), .MAX_SEL(5), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   err_cnt = 0;
   int   chk_cnt = 0;
   op_t  q0[$];
   op_t  q1[$];
   exp_t sb[$];
   logic [1:0] fire;

   // Behavioural ALU: result in the low bits, flags {cout, neg, zero, ovf} above them.
   function automatic logic [W+3:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [SW-1:0] sel, input logic cin);
      logic [W-1:0] y;
      case (sel)
         4'd0:    y = a & b;
         4'd1:    y = a | b;
         4'd2:    y = ~a;
         4'd3:    y = ~(a | b);
         4'd4:    y = a ^ b;
         4'd5:    y = ~(a & b);
         default: y = '0;
      endcase
      return {cin, y[W-1], (y == '0), ^y, y};
   endfunction

   assign {bus.alu_cout, bus.alu_neg, bus.alu_zero, bus.alu_ovf, bus.alu_y} =
          alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_cin);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      chk_cnt++;
      if (obs !== want) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
      end
   endtask

   // Queue an op on port p and push its expected response (callers enqueue in grant order).
   task automatic enqueue(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SW-1:0] sel, input logic cin);
      op_t  o;
      exp_t e;
      logic [W+3:0] r;
      o.a = a; o.b = b; o.sel = sel; o.cin = cin;
      if (p == 0) q0.push_back(o); else q1.push_back(o);
      r     = alu_ref(a, b, sel, cin);
      e.id  = (p != 0);
      e.err = (sel > 4'd5);
      e.y   = e.err ? '0 : r[W-1:0];
      e.f   = e.err ? 4'h0 : r[W+3:W];
      sb.push_back(e);
   endtask

   // Request driver: presents the head of each port queue and holds it until the handshake.
   initial begin : drv
      fire = 2'b00;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = '0; bus.req0_cin = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = '0; bus.req1_cin = 1'b0;
      forever begin
         @(negedge clk);
         if (fire[0] && q0.size() > 0) q0.delete(0);
         if (fire[1] && q1.size() > 0) q1.delete(0);
         if (q0.size() > 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = q0[0].a; bus.req0_b = q0[0].b;
            bus.req0_sel = q0[0].sel; bus.req0_cin = q0[0].cin;
         end else begin
            bus.req0_valid = 1'b0;
         end
         if (q1.size() > 0) begin
            bus.req1_valid = 1'b1; bus.req1_a = q1[0].a; bus.req1_b = q1[0].b;
            bus.req1_sel = q1[0].sel; bus.req1_cin = q1[0].cin;
         end else begin
            bus.req1_valid = 1'b0;
         end
         #1;
         fire[0] = rst_n & bus.req0_valid & bus.req0_ready;
         fire[1] = rst_n & bus.req1_valid & bus.req1_ready;
      end
   end

   // Response monitor: every delivered response is popped from the scoreboard and compared.
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_rsp", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               $display("rsp id=%0d y=%h flags=%b err=%0d", bus.rsp_id, bus.rsp_y, bus.rsp_flags, bus.rsp_err);
               chk("rsp_id", bus.rsp_id, e.id);
               chk("rsp_y", bus.rsp_y, e.y);
               chk("rsp_flags", bus.rsp_flags, e.f);
               chk("rsp_err", bus.rsp_err, e.err);
            end
         end
      end
   end

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (!(sb.size() == 0 && q0.size() == 0 && q1.size() == 0 && !bus.busy && fire == 2'b00) && n < 300);
      if (n >= 300) begin
         chk({tag, "_timeout"}, 64'd1, 64'd0);
         sb.delete(); q0.delete(); q1.delete();
      end
   endtask

   task automatic wait_fire(input int p, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (!fire[p] && n < 50);
      if (n >= 50) chk({tag, "_accept_timeout"}, 64'd1, 64'd0);
   endtask

   // Counts negedges from the accept edge until rsp_valid is seen.
   task automatic check_latency(input int p, input int want, input string tag);
      int n;
      wait_fire(p, tag);
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (!bus.rsp_valid && n < 10);
      chk(tag, n, want);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [W+3:0] r;
      bus.rsp_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      // Reset state
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_alu_sel", bus.alu_sel, 0);
      chk("rst_alu_cin", bus.alu_cin, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_y", bus.rsp_y, 0);
      chk("rst_rsp_flags", bus.rsp_flags, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_cnt0", bus.cnt0, 0);
      chk("rst_cnt1", bus.cnt1, 0);
      chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
      rst_n = 1'b1;

      // Single AND op on port 0
      enqueue(0, 32'h0000_000F, 32'h0000_0003, 4'd0, 1'b0);
      check_latency(0, 2, "lat_single");
      wait_idle("single");
      chk("single_cnt0", bus.cnt0, 1);
      chk("single_cnt1", bus.cnt1, 0);
      chk("hold_alu_a", bus.alu_a, 32'h0000_000F);
      chk("hold_alu_b", bus.alu_b, 32'h0000_0003);

      // Contest: both ports valid coming out of reset, grants alternate 0,1,0,1
      rst_n = 1'b0;
      enqueue(0, 32'hAAAA_0000, 32'h0F0F_FFFF, 4'd1, 1'b0);
      enqueue(1, 32'h1234_5678, 32'hFFFF_0000, 4'd0, 1'b1);
      enqueue(0, 32'h8000_0001, 32'h0000_0000, 4'd2, 1'b0);
      enqueue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_idle("contest");
      chk("contest_cnt0", bus.cnt0, 2);
      chk("contest_cnt1", bus.cnt1, 2);

      // Backpressure: response held for 5 cycles while port 1 waits
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      enqueue(0, 32'h1234_5678, 32'h0F0F_0F0F, 4'd4, 1'b1);
      r = alu_ref(32'h1234_5678, 32'h0F0F_0F0F, 4'd4, 1'b1);
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            #2;
            n++;
         end while (!bus.rsp_valid && n < 20);
         chk("bp_rsp_valid_seen", bus.rsp_valid, 1);
      end
      enqueue(1, 32'hC000_0003, 32'h0000_0030, 4'd1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #2;
         chk("bp_rsp_valid", bus.rsp_valid, 1);
         chk("bp_rsp_id", bus.rsp_id, 0);
         chk("bp_rsp_y", bus.rsp_y, r[W-1:0]);
         chk("bp_ready", {bus.req1_ready, bus.req0_ready}, 0);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      wait_idle("backpressure");

      // Illegal select on port 1: no ALU issue, one-cycle latency, operands untouched
      enqueue(1, 32'hDEAD_BEEF, 32'h1111_1111, 4'b1001, 1'b1);
      check_latency(1, 1, "lat_illegal");
      chk("illegal_alu_sel", bus.alu_sel, 4'd1);
      chk("illegal_alu_a", bus.alu_a, 32'hC000_0003);
      chk("illegal_alu_cin", bus.alu_cin, 0);
      wait_idle("illegal");

      // Reset during ISSUE drops the op and clears everything immediately
      enqueue(1, 32'h5555_5555, 32'h3333_3333, 4'd5, 1'b1);
      wait_fire(1, "rst_mid");
      @(negedge clk);
      #3;
      chk("mid_busy_issue", bus.busy, 1);
      chk("mid_alu_a_issue", bus.alu_a, 32'h5555_5555);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_alu_a", bus.alu_a, 0);
      chk("mid_rst_alu_sel", bus.alu_sel, 0);
      chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
      chk("mid_rst_cnt", {bus.cnt1, bus.cnt0}, 0);
      sb.delete();
      enqueue(0, 32'h0000_FFFF, 32'h00FF_00FF, 4'd3, 1'b0);
      enqueue(1, 32'h7FFF_FFFF, 32'h0000_0001, 4'd0, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_idle("post_reset");
      chk("post_rst_cnt0", bus.cnt0, 1);
      chk("post_rst_cnt1", bus.cnt1, 1);

      // Counter saturation: five more ops on port 0
      for (int i = 0; i < 5; i++) begin
         enqueue(0, 32'h0101_0101 * (i + 1), 32'hF0F0_F0F0, 4'(i), i[0]);
      end
      wait_idle("saturate");
      chk("sat_cnt0", bus.cnt0, 3);
      chk("sat_cnt1", bus.cnt1, 1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU instance between two requesters. Round-robin arbitration, valid/ready handshakes on both sides.
- Sequences each operation: accept, then issue operands to the ALU for one cycle, then register the result and flags.
- Returns the registered result on a single tagged response channel.
- Sits between the ALU datapath and its clients, for example a decode stage and a test/DMA port.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU width.
- SEL_W, 4, operation-select width.
- MAX_SEL, 5, highest legal select code (0 AND, 1 OR, 2 NOT, 3 NOR, 4 XOR, 5 NAND).
- CNT_W, 16, width of per-requester completed-operation counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester n has an operation pending.
- req0_ready / req1_ready  out  1  requester n's operation is accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_sel / req1_sel  in  SEL_W  operation code.
- req0_cin / req1_cin  in  1  carry-in.
- alu_a, alu_b  out  WIDTH  operands driven to the ALU.
- alu_sel  out  SEL_W  select driven to the ALU.
- alu_cin  out  1  carry-in driven to the ALU.
- alu_y  in  WIDTH  ALU result.
- alu_cout, alu_neg, alu_zero, alu_ovf  in  1 each  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the operation (0 or 1).
- rsp_y  out  WIDTH  registered result.
- rsp_flags  out  4  registered flags {cout, neg, zero, ovf}.
- rsp_err  out  1  select code was illegal (sel > MAX_SEL).
- cnt0 / cnt1  out  CNT_W  responses delivered to requester n.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset is asynchronous (rst_n low):
  - state=IDLE, last_grant=1, so requester 0 wins the first contest.
  - Operand/select/cin registers = 0, so alu_a, alu_b, alu_sel, alu_cin = 0.
  - rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err, cnt0, cnt1, busy = 0; req*_ready = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req*_ready is combinational. Only the granted requester's ready is high, and only in IDLE with its valid high.
  - Grant: a single valid port wins. If both are valid, the port != last_grant wins.
  - On handshake edge: capture a, b, sel, cin and the id; set last_grant=id.
  - Next state: ISSUE if sel <= MAX_SEL; otherwise RESP with rsp_err=1, rsp_y=0, rsp_flags=0. The ALU operand registers are not updated for an illegal op.
  - No valid: stay in IDLE.
- ISSUE (exactly one cycle):
  - alu_* outputs are driven from the captured registers.
  - At the edge, alu_y and flags are registered into rsp_y/rsp_flags, rsp_err=0, state -> RESP.
- RESP:
  - rsp_valid=1, and rsp_id/rsp_y/rsp_flags/rsp_err are held stable until rsp_ready.
  - On rsp_valid and rsp_ready at an edge: the selected cnt increments (saturating at all-ones), state -> IDLE, rsp_valid=0.
  - The next request cannot be accepted in the same cycle as the response handshake. Acceptance resumes the following cycle.
- Latency:
  - Legal op: accept at edge T, rsp_valid high after edge T+1.
  - Illegal op: rsp_valid high after edge T.
  - Throughput is at most one op per 3 cycles when rsp_ready is held high.
- alu_* outputs hold their last captured value outside ISSUE; they do not toggle while idle.
- Requests arriving outside IDLE see ready=0 and must stay valid; requesters do not drop valid before the handshake.
- rst_n asserted mid-operation drops the in-flight op immediately (async). No response is produced and counters clear.
- The arbiter does not modify results; all flag semantics come from the ALU.

Test Plan:
- Single op: req0 a=0x0000000F, b=0x00000003, sel=0 (AND), cin=0; rsp_ready=1 -> rsp_valid 2 cycles after accept; rsp_id=0, rsp_y=alu_y driven back by the bench model, cnt0=1.
- Contest: req0 and req1 both valid from reset -> req0 granted first, then req1. Hold both valid continuously -> grants alternate 0,1,0,1; cnt0 = cnt1 after 4 ops.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_y and rsp_id held stable; req*_ready stays 0; a single op completes when rsp_ready rises.
- Illegal select: req1 sel=4'b1001 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_y=0, rsp_flags=0; alu_sel unchanged from its previous value.
- Reset mid-op: deassert rst_n during ISSUE -> all outputs 0 immediately. After release, req0 wins the next contest and cnt0=cnt1=0.
- Counter saturation with CNT_W=2: 5 ops on req0 -> cnt0 stays at 3.
